// File: rtl/id_ex_if.sv
// Decode/execute boundary bundle: decode-slot fields, downstream stage status,
// pipeline control, and the registered/forwarded EX-slot outputs.
interface id_ex_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic          id_use_imm;
    logic [2:0]    id_op;
    logic          id_inva;
    logic          id_invb;
    logic          id_cin;
    logic          id_sign;
    logic [RW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;

    logic          exm_valid;
    logic          exm_reg_write;
    logic          exm_mem_read;
    logic [RW-1:0] exm_rd;
    logic [DW-1:0] exm_result;
    logic          mwb_valid;
    logic          mwb_reg_write;
    logic [RW-1:0] mwb_rd;
    logic [DW-1:0] mwb_data;

    logic          hold;
    logic          flush;

    logic          ex_valid;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [2:0]    ex_op;
    logic          ex_inva;
    logic          ex_invb;
    logic          ex_cin;
    logic          ex_sign;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [DW-1:0] ex_store_data;
    logic          stall_id;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rs_data, id_rt_data,
               id_imm, id_use_imm, id_op, id_inva, id_invb, id_cin, id_sign, id_rd,
               id_reg_write, id_mem_read, id_mem_write,
               exm_valid, exm_reg_write, exm_mem_read, exm_rd, exm_result,
               mwb_valid, mwb_reg_write, mwb_rd, mwb_data, hold, flush,
        input  ex_valid, ex_a, ex_b, ex_op, ex_inva, ex_invb, ex_cin, ex_sign, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, stall_id
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rs_data, id_rt_data,
               id_imm, id_use_imm, id_op, id_inva, id_invb, id_cin, id_sign, id_rd,
               id_reg_write, id_mem_read, id_mem_write,
               exm_valid, exm_reg_write, exm_mem_read, exm_rd, exm_result,
               mwb_valid, mwb_reg_write, mwb_rd, mwb_data, hold, flush,
        output ex_valid, ex_a, ex_b, ex_op, ex_inva, ex_invb, ex_cin, ex_sign, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, stall_id
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use bubble insertion. Update priority: rst > hold > flush > load-use > load.
module id_ex_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic    clk,
    input  logic    rst,
    id_ex_if.slave  bus
);
    logic          r_valid;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic          r_rs_used;
    logic          r_rt_used;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic          r_use_imm;
    logic [2:0]    r_op;
    logic          r_inva;
    logic          r_invb;
    logic          r_cin;
    logic          r_sign;
    logic [RW-1:0] r_rd;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;

    logic          w_load_use;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    // A load still in EX cannot supply its data before the dependent instruction needs it.
    assign w_load_use = r_valid & r_mem_read & r_reg_write & bus.id_valid & ~bus.flush &
                        ((bus.id_rs_used & (bus.id_rs == r_rd)) |
                         (bus.id_rt_used & (bus.id_rt == r_rd)));

    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic          used,
        input logic [DW-1:0] rf_data,
        input logic          exm_valid,
        input logic          exm_reg_write,
        input logic          exm_mem_read,
        input logic [RW-1:0] exm_rd,
        input logic [DW-1:0] exm_result,
        input logic          mwb_valid,
        input logic          mwb_reg_write,
        input logic [RW-1:0] mwb_rd,
        input logic [DW-1:0] mwb_data
    );
        logic [DW-1:0] v;
        v = rf_data;
        if (used) begin
            // A load in EX/MEM has no data yet, so only MEM/WB can supply it.
            if (exm_valid && exm_reg_write && !exm_mem_read && (exm_rd == src))
                v = exm_result;
            else if (mwb_valid && mwb_reg_write && (mwb_rd == src))
                v = mwb_data;
        end
        return v;
    endfunction

    always_comb begin
        w_fwd_rs = fwd_sel(r_rs, r_rs_used, r_rs_data,
                           bus.exm_valid, bus.exm_reg_write, bus.exm_mem_read, bus.exm_rd,
                           bus.exm_result, bus.mwb_valid, bus.mwb_reg_write, bus.mwb_rd,
                           bus.mwb_data);
        w_fwd_rt = fwd_sel(r_rt, r_rt_used, r_rt_data,
                           bus.exm_valid, bus.exm_reg_write, bus.exm_mem_read, bus.exm_rd,
                           bus.exm_result, bus.mwb_valid, bus.mwb_reg_write, bus.mwb_rd,
                           bus.mwb_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_used   <= 1'b0;
            r_rt_used   <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_op        <= '0;
            r_inva      <= 1'b0;
            r_invb      <= 1'b0;
            r_cin       <= 1'b0;
            r_sign      <= 1'b0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (bus.hold) begin
            r_valid <= r_valid;
        end else if (bus.flush || w_load_use) begin
            // Bubble: datapath fields keep stale values, side-effecting controls are killed.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= bus.id_valid;
            r_rs        <= bus.id_rs;
            r_rt        <= bus.id_rt;
            r_rs_used   <= bus.id_rs_used;
            r_rt_used   <= bus.id_rt_used;
            r_rs_data   <= bus.id_rs_data;
            r_rt_data   <= bus.id_rt_data;
            r_imm       <= bus.id_imm;
            r_use_imm   <= bus.id_use_imm;
            r_op        <= bus.id_op;
            r_inva      <= bus.id_inva;
            r_invb      <= bus.id_invb;
            r_cin       <= bus.id_cin;
            r_sign      <= bus.id_sign;
            r_rd        <= bus.id_rd;
            r_reg_write <= bus.id_reg_write;
            r_mem_read  <= bus.id_mem_read;
            r_mem_write <= bus.id_mem_write;
        end
    end

    assign bus.ex_valid      = r_valid;
    assign bus.ex_a          = w_fwd_rs;
    assign bus.ex_b          = r_use_imm ? r_imm : w_fwd_rt;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ex_op         = r_op;
    assign bus.ex_inva       = r_inva;
    assign bus.ex_invb       = r_invb;
    assign bus.ex_cin        = r_cin;
    assign bus.ex_sign       = r_sign;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;
    assign bus.stall_id      = ~rst & (bus.hold | w_load_use);
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed forwarding/hazard/hold scenarios followed by
// randomized traffic, all checked against a slot-level reference model.
module tb_id_ex_stage;
    localparam int DW = 16;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_if #(.DW(DW), .RW(RW)) bus ();

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          rs_used;
        logic          rt_used;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic          use_imm;
        logic [2:0]    op;
        logic          inva;
        logic          invb;
        logic          cin;
        logic          sign;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          mw;
    } slot_t;

    slot_t m;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Newest value of a register as seen by EX: the youngest eligible producer wins.
    function automatic logic [DW-1:0] model_operand(input logic [RW-1:0] src, input logic used,
                                                    input logic [DW-1:0] rf);
        logic          pv[2];
        logic [RW-1:0] pr[2];
        logic [DW-1:0] pd[2];
        if (!used) return rf;
        pv[0] = bus.exm_valid && bus.exm_reg_write && !bus.exm_mem_read;
        pr[0] = bus.exm_rd;  pd[0] = bus.exm_result;
        pv[1] = bus.mwb_valid && bus.mwb_reg_write;
        pr[1] = bus.mwb_rd;  pd[1] = bus.mwb_data;
        for (int k = 0; k < 2; k++)
            if (pv[k] && pr[k] == src) return pd[k];
        return rf;
    endfunction

    function automatic logic model_load_use();
        logic dep;
        dep = (bus.id_rs_used && bus.id_rs == m.rd) || (bus.id_rt_used && bus.id_rt == m.rd);
        return m.valid && m.mr && m.rw && bus.id_valid && !bus.flush && dep;
    endfunction

    task automatic model_edge();
        slot_t n;
        n = m;
        if (rst) n = '0;
        else if (bus.hold) n = m;
        else if (bus.flush || model_load_use()) begin
            n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
        end else begin
            n = '{bus.id_valid, bus.id_rs, bus.id_rt, bus.id_rs_used, bus.id_rt_used,
                  bus.id_rs_data, bus.id_rt_data, bus.id_imm, bus.id_use_imm, bus.id_op,
                  bus.id_inva, bus.id_invb, bus.id_cin, bus.id_sign, bus.id_rd,
                  bus.id_reg_write, bus.id_mem_read, bus.id_mem_write};
        end
        m = n;
    endtask

    task automatic check_all();
        logic [DW-1:0] a, rt;
        check_val("stall_id", bus.stall_id, !rst && (bus.hold || model_load_use()));
        check_val("ex_valid", bus.ex_valid, m.valid);
        check_val("ex_ctrl", {bus.ex_op, bus.ex_inva, bus.ex_invb, bus.ex_cin, bus.ex_sign},
                  {m.op, m.inva, m.invb, m.cin, m.sign});
        check_val("ex_wb", {bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
                  {m.rd, m.rw, m.mr, m.mw});
        if (m.valid) begin
            a  = model_operand(m.rs, m.rs_used, m.rs_data);
            rt = model_operand(m.rt, m.rt_used, m.rt_data);
            check_val("ex_a", bus.ex_a, a);
            check_val("ex_b", bus.ex_b, m.use_imm ? m.imm : rt);
            check_val("ex_store_data", bus.ex_store_data, rt);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Inputs are driven at posedge+1; checks land mid-cycle, well before the next edge.
    task automatic cycle();
        settle();
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
        bus.id_op = 0; bus.id_inva = 0; bus.id_invb = 0; bus.id_cin = 0; bus.id_sign = 0;
        bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.exm_valid = 0; bus.exm_reg_write = 0; bus.exm_mem_read = 0; bus.exm_rd = 0;
        bus.exm_result = 0; bus.mwb_valid = 0; bus.mwb_reg_write = 0; bus.mwb_rd = 0;
        bus.mwb_data = 0; bus.hold = 0; bus.flush = 0;
    endtask

    task automatic put_load(input logic [RW-1:0] rd);
        idle();
        bus.id_valid = 1; bus.id_rd = rd; bus.id_reg_write = 1; bus.id_mem_read = 1;
        bus.id_rs = 7; bus.id_rs_used = 1;
        cycle();
    endtask

    task automatic randomize_inputs();
        rst = ($urandom_range(0, 63) == 0);
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.id_rs = RW'($urandom_range(0, 7));  bus.id_rt = RW'($urandom_range(0, 7));
        bus.id_rs_used = $urandom_range(0, 1);  bus.id_rt_used = $urandom_range(0, 1);
        bus.id_rs_data = DW'($urandom);         bus.id_rt_data = DW'($urandom);
        bus.id_imm = DW'($urandom);             bus.id_use_imm = $urandom_range(0, 1);
        bus.id_op = 3'($urandom_range(0, 7));
        {bus.id_inva, bus.id_invb, bus.id_cin, bus.id_sign} = 4'($urandom_range(0, 15));
        bus.id_rd = RW'($urandom_range(0, 7));
        bus.id_reg_write = ($urandom_range(0, 3) != 0);
        bus.id_mem_read = ($urandom_range(0, 2) == 0);
        bus.id_mem_write = ($urandom_range(0, 5) == 0);
        bus.exm_valid = $urandom_range(0, 1);   bus.exm_reg_write = $urandom_range(0, 1);
        bus.exm_mem_read = ($urandom_range(0, 3) == 0);
        bus.exm_rd = RW'($urandom_range(0, 7)); bus.exm_result = DW'($urandom);
        bus.mwb_valid = $urandom_range(0, 1);   bus.mwb_reg_write = $urandom_range(0, 1);
        bus.mwb_rd = RW'($urandom_range(0, 7)); bus.mwb_data = DW'($urandom);
        bus.hold = ($urandom_range(0, 7) == 0);
        bus.flush = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW+8:0] snap;
        m = '0;
        idle();
        // Reset with a valid decode slot; second cycle also raises hold.
        rst = 1; bus.id_valid = 1; bus.id_reg_write = 1; bus.id_mem_read = 1;
        @(posedge clk); model_edge(); #1;
        bus.hold = 1;
        @(posedge clk); model_edge(); #1;
        settle();
        check_val("rst_ex_valid", bus.ex_valid, 0);
        check_val("rst_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_op}, 0);
        check_val("rst_stall", bus.stall_id, 0);
        cycle();

        // EX/MEM forwarding wins over MEM/WB.
        idle();
        bus.id_valid = 1; bus.id_rs = 3; bus.id_rs_used = 1; bus.id_rs_data = 16'h0000;
        bus.id_rd = 1; bus.id_reg_write = 1;
        cycle();
        bus.id_valid = 0;
        bus.exm_valid = 1; bus.exm_reg_write = 1; bus.exm_rd = 3; bus.exm_result = 16'h1234;
        settle();
        check_val("exm_fwd_a", bus.ex_a, 16'h1234);
        bus.mwb_valid = 1; bus.mwb_reg_write = 1; bus.mwb_rd = 3; bus.mwb_data = 16'hBEEF;
        settle();
        check_val("exm_over_mwb", bus.ex_a, 16'h1234);
        cycle();

        // MEM/WB forwarding into B and store data, with and without immediate.
        idle();
        bus.id_valid = 1; bus.id_rt = 5; bus.id_rt_used = 1; bus.id_rt_data = 16'h0000;
        bus.mwb_valid = 1; bus.mwb_reg_write = 1; bus.mwb_rd = 5; bus.mwb_data = 16'h00FF;
        cycle();
        settle();
        check_val("mwb_fwd_b", bus.ex_b, 16'h00FF);
        bus.id_use_imm = 1; bus.id_imm = 16'h0007;
        cycle();
        settle();
        check_val("imm_b", bus.ex_b, 16'h0007);
        check_val("imm_store", bus.ex_store_data, 16'h00FF);
        cycle();

        // Load-use: one bubble, then the dependent instruction latches and forwards.
        put_load(2);
        bus.id_valid = 1; bus.id_rs = 2; bus.id_rs_used = 1; bus.id_rs_data = 16'h1111;
        bus.id_rd = 4; bus.id_reg_write = 1; bus.id_mem_read = 0;
        settle();
        check_val("lu_stall", bus.stall_id, 1);
        cycle();
        settle();
        check_val("lu_bubble", bus.ex_valid, 0);
        check_val("lu_stall_once", bus.stall_id, 0);
        bus.mwb_valid = 1; bus.mwb_reg_write = 1; bus.mwb_rd = 2; bus.mwb_data = 16'hCAFE;
        cycle();
        settle();
        check_val("lu_latched", bus.ex_valid, 1);
        check_val("lu_fwd_a", bus.ex_a, 16'hCAFE);
        cycle();

        // Flush overrides load-use; an unused matching source does not stall.
        put_load(2);
        bus.id_valid = 1; bus.id_rs = 2; bus.id_rs_used = 1; bus.id_mem_read = 0;
        bus.flush = 1;
        settle();
        check_val("flush_no_stall", bus.stall_id, 0);
        cycle();
        settle();
        check_val("flush_kill", bus.ex_valid, 0);
        put_load(2);
        bus.id_valid = 1; bus.id_rs = 2; bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_mem_read = 0;
        settle();
        check_val("unused_no_stall", bus.stall_id, 0);
        cycle();

        // Hold for three cycles with changing decode inputs, then reset during hold.
        idle();
        bus.id_valid = 1; bus.id_op = 3'd5; bus.id_rd = 6; bus.id_reg_write = 1;
        bus.id_mem_write = 1; bus.id_cin = 1;
        cycle();
        snap = {bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_write,
                bus.ex_cin, 6'd0, 3'd0};
        for (int i = 0; i < 3; i++) begin
            bus.hold = 1; bus.id_op = 3'($urandom_range(0, 4)); bus.id_rd = 3'(i);
            bus.id_valid = i[0]; bus.flush = i[1];
            settle();
            check_val("hold_stall", bus.stall_id, 1);
            cycle();
            check_val("hold_keep", {bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_reg_write,
                      bus.ex_mem_write, bus.ex_cin, 6'd0, 3'd0}, snap);
        end
        rst = 1;
        cycle();
        settle();
        check_val("rst_in_hold", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write}, 0);

        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
